// File: rtl/positadd_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module   : positadd_arb_pkg
// Summary  : Shared constants and tag type for the posit-adder arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package positadd_arb_pkg;

    localparam int POSIT_N     = 32;
    localparam int POSIT_ES    = 3;
    localparam int ADD_LATENCY = 4;

    // Sized for the largest supported requester count (8).
    localparam int TAG_IDX_W   = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : rr_arbiter
// Summary  : Combinational round-robin pick of the first request at or after ptr.
// Revision : 1.0 - initial release
//==============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!any && req[w_cand]) begin
                any           = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/positadd_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : positadd_arbiter
// Summary  : Shares one fixed-latency posit adder among NUM_REQ requesters.
// Revision : 1.0 - initial release
//==============================================================================
module positadd_arbiter
    import positadd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int N       = POSIT_N,
    parameter int LATENCY = ADD_LATENCY,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*N-1:0]     req_in1,
    input  logic [NUM_REQ*N-1:0]     req_in2,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [N-1:0]             rsp_result,
    output logic                     rsp_inf,
    output logic                     rsp_zero,
    output logic [N-1:0]             add_in1,
    output logic [N-1:0]             add_in2,
    output logic                     add_start,
    input  logic [N-1:0]             add_result,
    input  logic                     add_inf,
    input  logic                     add_zero,
    input  logic                     add_done,
    output logic [IDX_W+LATENCY-1:0] inflight,
    output logic                     tag_err
);

    localparam int DRAIN_W = $clog2(LATENCY + 1);
    localparam int INFL_W  = IDX_W + LATENCY;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_hs;
    logic [DRAIN_W-1:0] r_drain;
    logic               w_drain_done;

    logic               r_add_start;
    logic [IDX_W-1:0]   r_issue_idx;
    logic [N-1:0]       r_add_in1;
    logic [N-1:0]       r_add_in2;

    tag_t               r_tag [LATENCY];
    tag_t               w_last;
    logic [IDX_W-1:0]   w_last_idx;
    logic               w_match;

    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [N-1:0]       r_rsp_result;
    logic               r_rsp_inf;
    logic               r_rsp_zero;
    logic [INFL_W-1:0]  r_inflight;
    logic               r_tag_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .any       (w_any)
    );

    assign w_drain_done = (r_drain == '0);
    assign req_ready    = (!reset && w_drain_done) ? w_grant : '0;
    assign w_hs         = w_any && !reset && w_drain_done;

    // Issue stage: capture the granted operands and advance the priority pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain     <= DRAIN_W'(LATENCY);
            r_rr_ptr    <= '0;
            r_add_start <= 1'b0;
            r_issue_idx <= '0;
            r_add_in1   <= '0;
            r_add_in2   <= '0;
        end else begin
            if (!w_drain_done) begin
                r_drain <= r_drain - DRAIN_W'(1);
            end
            r_add_start <= w_hs;
            if (w_hs) begin
                r_issue_idx <= w_gidx;
                r_add_in1   <= req_in1[w_gidx*N +: N];
                r_add_in2   <= req_in2[w_gidx*N +: N];
                r_rr_ptr    <= (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + IDX_W'(1);
            end
        end
    end

    // Stage 0 samples the strobe being driven now, so the last stage lines up with add_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= tag_t'{valid: r_add_start, idx: TAG_IDX_W'(r_issue_idx)};
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_last     = r_tag[LATENCY-1];
    assign w_last_idx = IDX_W'(w_last.idx);
    assign w_match    = add_done && w_last.valid && w_drain_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_inf    <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_inflight   <= '0;
            r_tag_err    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_match) begin
                r_rsp_valid  <= NUM_REQ'(1) << w_last_idx;
                r_rsp_result <= add_result;
                r_rsp_inf    <= add_inf;
                r_rsp_zero   <= add_zero;
            end
            if (r_add_start && !w_match) begin
                r_inflight <= r_inflight + INFL_W'(1);
            end else if (!r_add_start && w_match) begin
                r_inflight <= r_inflight - INFL_W'(1);
            end
            if (w_drain_done && (add_done != w_last.valid)) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign add_start  = r_add_start;
    assign add_in1    = r_add_in1;
    assign add_in2    = r_add_in2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_inf    = r_rsp_inf;
    assign rsp_zero   = r_rsp_zero;
    assign inflight   = r_inflight;
    assign tag_err    = r_tag_err;

endmodule
`default_nettype wire

// File: doc/positadd_arbiter.md
Name: positadd_arbiter

Overview:
- Shares one pipelined 32-bit posit adder (es=3, fixed start-to-done latency) among NUM_REQ requesters.
- Each requester has a valid/ready port. The arbiter grants one request per cycle, round-robin, and drives the adder's start and operands.
- Each issued operation is tracked by a requester tag that travels through a shadow shift register. The adder result is returned to the owning requester on the cycle done rises.
- Sits between the PairHMM compute lanes and the shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- N, 32, posit word width
- LATENCY, 4, adder cycles from start to done (≥1)
- IDX_W, $clog2(NUM_REQ), tag width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_in1  in  NUM_REQ*N  operand A, requester i at bits [i*N +: N]
- req_in2  in  NUM_REQ*N  operand B, same packing
- rsp_valid  out  NUM_REQ  one-hot result strobe
- rsp_result  out  N  result, broadcast to all requesters
- rsp_inf  out  1  result is NaR/inf
- rsp_zero  out  1  result is zero
- add_in1  out  N  operand A to adder
- add_in2  out  N  operand B to adder
- add_start  out  1  adder issue strobe
- add_result  in  N  adder result
- add_inf  in  1  adder inf flag
- add_zero  in  1  adder zero flag
- add_done  in  1  adder result valid
- inflight  out  IDX_W+LATENCY bits (sized to hold 0..LATENCY)  number of operations in the adder
- tag_err  out  1  sticky protocol error

Behaviour:
- One clock domain. Reset is synchronous and active-high. All registers update on the rising edge of clk.
- Reset values:
  - req_ready=0, add_start=0, add_in1/add_in2=0
  - rsp_valid=0, rsp_result=0, rsp_inf=0, rsp_zero=0
  - inflight=0, tag_err=0
  - rr_ptr=0, tag pipe cleared, drain counter=LATENCY
- Arbitration is combinational on req_valid and the registered rr_ptr:
  - Grant the first valid requester at index ≥ rr_ptr, wrapping around.
  - req_ready[g]=1 only for the granted index g, and only when not in reset.
  - Handshake completes when req_valid[g] && req_ready[g]. A requester must hold valid and operands stable until it sees ready.
- Issue is registered:
  - On handshake, next cycle add_start=1 and add_in1/add_in2 carry that requester's operands.
  - Otherwise add_start=0 and the operands hold their last values.
  - rr_ptr becomes (g+1) mod NUM_REQ on handshake; otherwise it holds.
- Tag pipe:
  - LATENCY-deep shift register of {valid, idx}.
  - Stage 0 loads {add_start, issued idx} in the same cycle add_start is driven.
  - Shifts every cycle with no stall; the adder cannot stall.
- Response:
  - On add_done=1 with the last tag stage valid: rsp_valid[idx]=1 and rsp_result/inf/zero are registered from the adder outputs.
  - Response latency is 1 cycle after add_done.
  - Requesters must always accept; there is no response backpressure.
- Throughput: one issue per cycle. Total latency from handshake to rsp_valid is LATENCY+2 cycles.
- inflight:
  - +1 on add_start, −1 on a matched add_done; both in the same cycle leaves it unchanged.
  - Never exceeds LATENCY.
- Error detection:
  - tag_err is set, and stays set until reset, when add_done differs from the last tag stage's valid bit.
  - In the mismatch case rsp_valid stays 0.
- Reset mid-operation:
  - In-flight results are dropped.
  - The drain counter suppresses add_done handling and tag_err for LATENCY cycles after reset deasserts. req_ready stays 0 while the drain counter is nonzero.
- NUM_REQ=1: rr_ptr is fixed at 0 and ready follows not-draining.
- A requester may receive a response and a new grant in the same cycle.

Decomposition:
- Package positadd_arb_pkg holds:
  - localparam POSIT_N=32, POSIT_ES=3, ADD_LATENCY=4
  - typedef tag_t {logic valid; logic [IDX_W-1:0] idx;}
- One sub-module, rr_arbiter: combinational round-robin priority pick from (req, ptr) to (grant one-hot, grant index, any).

Test Plan:
- Single op: requester 1 sends in1=in2=0x40000000 (1.0) → add_start one cycle after handshake; rsp_valid=4'b0010 LATENCY+1 cycles after add_start; rsp_result=0x44000000 (2.0); rsp_inf=0, rsp_zero=0.
- Full contention: all 4 requesters hold valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3; responses arrive in the same order; inflight saturates at 4.
- Zero and inf: in1=0x40000000, in2=0xC0000000 (−1.0) → rsp_zero=1, result 0x00000000. in1=0x80000000 → rsp_inf=1.
- Reset mid-flight: assert reset for 1 cycle with 3 ops in flight → no rsp_valid afterwards; tag_err=0; req_ready=0 for LATENCY cycles; the next op completes normally.
- Protocol error: inject a spurious add_done with an empty tag pipe (after drain) → tag_err=1 and stays set; rsp_valid=0.
- Back-to-back same requester: only requester 2 valid for 5 cycles → 5 consecutive grants to 2; 5 consecutive rsp_valid=4'b0100.
